// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
// Holds the arbiter state encoding and the cache-line offset helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam int         LINE_W_DEF = 256;
    localparam int         LINE_OFF   = $clog2(LINE_W_DEF / 8);
    localparam logic [3:0] STARVE_MAX = 4'd15;

    function automatic int line_offset(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Simulation checks on requester protocol and downstream strobe exclusivity.
module mem_port_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic d_read,
    input logic d_write,
    input logic pmem_read,
    input logic pmem_write
);

    // Sample protocol rules on every active clock edge outside reset
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(d_read && d_write))
                else $warning("mem_port_arbiter: d_read and d_write both high, write takes precedence");
            assert (!(pmem_read && pmem_write))
                else $error("mem_port_arbiter: pmem_read and pmem_write both high");
        end
    end

endmodule

// File: rtl/mem_port_arbiter_reg.sv
// Generic enabled register with asynchronous and synchronous clear.
module mem_port_arbiter_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage element: clears on either reset, loads when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {W{1'b0}};
        end else if (srst) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between instruction fetch and data memory.
// Data side wins ties; a starvation counter bounds how long fetch can wait.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int OFF = line_offset(LINE_W);

    arb_state_t        state_r;
    logic [3:0]        starve_r;
    logic              pmem_read_r;
    logic              pmem_write_r;
    logic              i_resp_r;
    logic              d_resp_r;

    logic              d_req_s;
    logic              grant_d_s;
    logic              grant_i_s;
    logic              grant_s;
    logic              capture_i_s;
    logic              capture_d_s;
    logic [ADDR_W-1:0] grant_addr_s;
    logic [LINE_W-1:0] grant_wdata_s;
    logic [LINE_W-1:0] i_line_s;
    logic [LINE_W-1:0] d_line_s;

    // Arbitration in IDLE: D wins unless fetch has waited STARVE_LIMIT grants
    always_comb begin
        d_req_s   = d_read | d_write;
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == IDLE) begin
            if (d_req_s && (!i_read || (starve_r < 4'(STARVE_LIMIT)))) begin
                grant_d_s = 1'b1;
            end else if (i_read) begin
                grant_i_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Values latched at grant time and line data steered at completion
    always_comb begin
        grant_s       = grant_d_s | grant_i_s;
        grant_addr_s  = {ADDR_W{1'b0}};
        grant_wdata_s = {LINE_W{1'b0}};
        if (grant_d_s) begin
            grant_addr_s  = {d_address[ADDR_W-1:OFF], {OFF{1'b0}}};
            grant_wdata_s = d_wdata;
        end else begin
            grant_addr_s  = {i_address[ADDR_W-1:OFF], {OFF{1'b0}}};
        end
        capture_i_s = (state_r == BUSY_I) && pmem_resp;
        capture_d_s = (state_r == BUSY_D) && pmem_resp;
        i_line_s    = capture_i_s ? pmem_rdata : {LINE_W{1'b0}};
        d_line_s    = capture_d_s ? pmem_rdata : {LINE_W{1'b0}};
    end

    mem_port_arbiter_reg #(.W(ADDR_W)) u_addr_reg (
        .clk(clk), .rst_n(rst_n), .srst(1'b0), .en(grant_s),
        .d(grant_addr_s), .q(pmem_address)
    );

    mem_port_arbiter_reg #(.W(LINE_W)) u_wdata_reg (
        .clk(clk), .rst_n(rst_n), .srst(1'b0), .en(grant_s),
        .d(grant_wdata_s), .q(pmem_wdata)
    );

    // Line registers are reloaded every cycle so rdata is zero outside RESP
    mem_port_arbiter_reg #(.W(LINE_W)) u_i_line_reg (
        .clk(clk), .rst_n(rst_n), .srst(1'b0), .en(1'b1),
        .d(i_line_s), .q(i_rdata)
    );

    mem_port_arbiter_reg #(.W(LINE_W)) u_d_line_reg (
        .clk(clk), .rst_n(rst_n), .srst(1'b0), .en(1'b1),
        .d(d_line_s), .q(d_rdata)
    );

    // Grant FSM, starvation counter and registered strobes/responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            starve_r     <= 4'd0;
            pmem_read_r  <= 1'b0;
            pmem_write_r <= 1'b0;
            i_resp_r     <= 1'b0;
            d_resp_r     <= 1'b0;
        end else begin
            i_resp_r <= 1'b0;
            d_resp_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        state_r      <= BUSY_D;
                        pmem_write_r <= d_write;
                        pmem_read_r  <= ~d_write;
                        if (i_read) begin
                            starve_r <= (starve_r == STARVE_MAX) ? starve_r : starve_r + 4'd1;
                        end else begin
                            starve_r <= 4'd0;
                        end
                    end else if (grant_i_s) begin
                        state_r      <= BUSY_I;
                        pmem_read_r  <= 1'b1;
                        pmem_write_r <= 1'b0;
                        starve_r     <= 4'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (pmem_resp) begin
                        state_r      <= RESP;
                        pmem_read_r  <= 1'b0;
                        pmem_write_r <= 1'b0;
                        i_resp_r     <= (state_r == BUSY_I);
                        d_resp_r     <= (state_r == BUSY_D);
                    end else begin
                        state_r <= state_r;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    pmem_read_r  <= 1'b0;
                    pmem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read  = pmem_read_r;
    assign pmem_write = pmem_write_r;
    assign i_resp     = i_resp_r;
    assign d_resp     = d_resp_r;

    mem_port_arbiter_chk u_chk (
        .clk(clk), .rst_n(rst_n), .d_read(d_read), .d_write(d_write),
        .pmem_read(pmem_read_r), .pmem_write(pmem_write_r)
    );

endmodule
